// File: rtl/clock_hms_counter_pkg.sv
// Shared constants, widths and alarm state type for the time-of-day counter.
// Wrap-increment helpers keep modular field arithmetic in one place.
package clock_hms_counter_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

    typedef enum logic {
        IDLE = 1'b0,
        RING = 1'b1
    } alarm_state_e;

    function automatic logic [5:0] wrap_inc6(input logic [5:0] value, input logic [5:0] max);
        logic [5:0] result;
        if (value == max) begin
            result = 6'd0;
        end else begin
            result = value + 6'd1;
        end
        return result;
    endfunction

    function automatic logic [4:0] wrap_inc5(input logic [4:0] value, input logic [4:0] max);
        logic [4:0] result;
        if (value == max) begin
            result = 5'd0;
        end else begin
            result = value + 5'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/clock_hms_counter_bcd.sv
// Combinational 7-bit binary to two-digit BCD (inputs 0-99), tens digit in [7:4].
module bin_to_bcd7 (
    input  logic [6:0] bin,
    output logic [7:0] bcd
);

    logic [3:0] tens_s;
    logic [3:0] ones_s;

    // Tens by threshold count; ones fit in 4 bits so the remainder is taken mod 16.
    always_comb begin
        tens_s = 4'd0;
        for (int i = 1; i <= 9; i++) begin
            if (bin >= 7'(i * 10)) begin
                tens_s = tens_s + 4'd1;
            end else begin
                tens_s = tens_s;
            end
        end
        ones_s = bin[3:0] - (tens_s * 4'd10);
    end

    assign bcd = {tens_s, ones_s};

endmodule

// File: rtl/clock_hms_counter.sv
// Hours/minutes/seconds counter with day-rollover strobe, one daily alarm
// with a ring state machine, and BCD views for the display mux.
module clock_hms_counter
    import clock_hms_counter_pkg::*;
#(
    parameter int RING_SECONDS   = 60,
    parameter int ALARM_RST_HOUR = 7
) (
    input  logic        system_clk,
    input  logic        CR,
    input  logic        tick_1hz,
    input  logic        hour_add,
    input  logic        min_add,
    input  logic        sec_clr,
    input  logic        alarm_en,
    input  logic        alarm_hour_add,
    input  logic        alarm_min_add,
    input  logic        alarm_ack,
    output logic [4:0]  hour,
    output logic [5:0]  minute,
    output logic [5:0]  second,
    output logic [7:0]  hour_bcd,
    output logic [7:0]  min_bcd,
    output logic [7:0]  sec_bcd,
    output logic [7:0]  alarm_hour_bcd,
    output logic [7:0]  alarm_min_bcd,
    output logic        pulse_day,
    output logic        ring
);

    logic [HOUR_W-1:0] hour_q, hour_d;
    logic [MIN_W-1:0]  min_q, min_d;
    logic [SEC_W-1:0]  sec_q, sec_d;
    logic [HOUR_W-1:0] alarm_hour_q, alarm_hour_d;
    logic [MIN_W-1:0]  alarm_min_q, alarm_min_d;
    logic [5:0]        ring_cnt_q, ring_cnt_d;
    alarm_state_e      state_q, state_d;
    logic              pulse_day_q, pulse_day_d;
    logic              ring_q, ring_d;

    logic set_any_s;
    logic tick_cnt_s;
    logic sec_wrap_s;
    logic trigger_s;

    // Any set strobe swallows a coincident tick.
    assign set_any_s  = hour_add | min_add | sec_clr;
    assign tick_cnt_s = tick_1hz & ~set_any_s;
    assign sec_wrap_s = tick_cnt_s & (sec_q == SEC_MAX);

    // Time fields: set strobes act field-locally, counted ticks ripple carries.
    always_comb begin
        hour_d      = hour_q;
        min_d       = min_q;
        sec_d       = sec_q;
        pulse_day_d = 1'b0;
        if (set_any_s) begin
            if (hour_add) hour_d = wrap_inc5(hour_q, HOUR_MAX); else hour_d = hour_q;
            if (min_add)  min_d  = wrap_inc6(min_q, MIN_MAX);   else min_d  = min_q;
            if (sec_clr)  sec_d  = 6'd0;                        else sec_d  = sec_q;
        end else if (tick_cnt_s) begin
            sec_d = wrap_inc6(sec_q, SEC_MAX);
            if (sec_q == SEC_MAX) begin
                min_d = wrap_inc6(min_q, MIN_MAX);
                if (min_q == MIN_MAX) begin
                    hour_d      = wrap_inc5(hour_q, HOUR_MAX);
                    pulse_day_d = (hour_q == HOUR_MAX);
                end else begin
                    hour_d = hour_q;
                end
            end else begin
                min_d = min_q;
            end
        end else begin
            sec_d = sec_q;
        end
    end

    // Alarm setting fields: only their own add strobes change them.
    always_comb begin
        alarm_hour_d = alarm_hour_q;
        alarm_min_d  = alarm_min_q;
        if (alarm_hour_add) alarm_hour_d = wrap_inc5(alarm_hour_q, HOUR_MAX); else alarm_hour_d = alarm_hour_q;
        if (alarm_min_add)  alarm_min_d  = wrap_inc6(alarm_min_q, MIN_MAX);   else alarm_min_d  = alarm_min_q;
    end

    // Trigger only on a counted minute boundary landing on the alarm time.
    assign trigger_s = sec_wrap_s & alarm_en &
                       (hour_d == alarm_hour_q) & (min_d == alarm_min_q);

    // Alarm FSM next state; ring output is registered from the next state.
    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        case (state_q)
            IDLE: begin
                if (trigger_s) begin
                    state_d    = RING;
                    ring_cnt_d = 6'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            RING: begin
                if (alarm_ack || !alarm_en) begin
                    state_d = IDLE;
                end else if (tick_cnt_s) begin
                    ring_cnt_d = ring_cnt_q + 6'd1;
                    if ((ring_cnt_q + 6'd1) == 6'(RING_SECONDS)) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RING;
                    end
                end else begin
                    state_d = RING;
                end
            end
            default: begin
                state_d    = IDLE;
                ring_cnt_d = 6'd0;
            end
        endcase
        ring_d = (state_d == RING);
    end

    // State registers with synchronous reset overriding every other update.
    always_ff @(posedge system_clk) begin
        if (CR) begin
            hour_q       <= 5'd0;
            min_q        <= 6'd0;
            sec_q        <= 6'd0;
            alarm_hour_q <= 5'(ALARM_RST_HOUR);
            alarm_min_q  <= 6'd0;
            ring_cnt_q   <= 6'd0;
            state_q      <= IDLE;
            pulse_day_q  <= 1'b0;
            ring_q       <= 1'b0;
        end else begin
            hour_q       <= hour_d;
            min_q        <= min_d;
            sec_q        <= sec_d;
            alarm_hour_q <= alarm_hour_d;
            alarm_min_q  <= alarm_min_d;
            ring_cnt_q   <= ring_cnt_d;
            state_q      <= state_d;
            pulse_day_q  <= pulse_day_d;
            ring_q       <= ring_d;
        end
    end

    assign hour      = hour_q;
    assign minute    = min_q;
    assign second    = sec_q;
    assign pulse_day = pulse_day_q;
    assign ring      = ring_q;

    bin_to_bcd7 u_hour_bcd       (.bin({2'b00, hour_q}),       .bcd(hour_bcd));
    bin_to_bcd7 u_min_bcd        (.bin({1'b0, min_q}),         .bcd(min_bcd));
    bin_to_bcd7 u_sec_bcd        (.bin({1'b0, sec_q}),         .bcd(sec_bcd));
    bin_to_bcd7 u_alarm_hour_bcd (.bin({2'b00, alarm_hour_q}), .bcd(alarm_hour_bcd));
    bin_to_bcd7 u_alarm_min_bcd  (.bin({1'b0, alarm_min_q}),   .bcd(alarm_min_bcd));

endmodule

// File: tb/tb_clock_hms_counter.sv
// Self-checking bench: seconds-of-day reference model plus directed scenarios and random strobes.
module tb_clock_hms_counter;

    localparam int RING_SECONDS   = 60;
    localparam int ALARM_RST_HOUR = 7;

    logic       system_clk = 1'b0;
    logic       CR = 1'b0, tick_1hz = 1'b0, hour_add = 1'b0, min_add = 1'b0, sec_clr = 1'b0;
    logic       alarm_en = 1'b0, alarm_hour_add = 1'b0, alarm_min_add = 1'b0, alarm_ack = 1'b0;
    logic [4:0] hour;
    logic [5:0] minute, second;
    logic [7:0] hour_bcd, min_bcd, sec_bcd, alarm_hour_bcd, alarm_min_bcd;
    logic       pulse_day, ring;

    int checks_r = 0;
    int errors_r = 0;

    // Reference model state: time as seconds of day, alarm in hours/minutes.
    int m_tod = 0, m_ah = ALARM_RST_HOUR, m_am = 0, m_rcnt = 0;
    bit m_ring = 1'b0, m_pulse = 1'b0;

    clock_hms_counter #(.RING_SECONDS(RING_SECONDS), .ALARM_RST_HOUR(ALARM_RST_HOUR)) dut (
        .system_clk(system_clk), .CR(CR), .tick_1hz(tick_1hz),
        .hour_add(hour_add), .min_add(min_add), .sec_clr(sec_clr),
        .alarm_en(alarm_en), .alarm_hour_add(alarm_hour_add),
        .alarm_min_add(alarm_min_add), .alarm_ack(alarm_ack),
        .hour(hour), .minute(minute), .second(second),
        .hour_bcd(hour_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
        .alarm_hour_bcd(alarm_hour_bcd), .alarm_min_bcd(alarm_min_bcd),
        .pulse_day(pulse_day), .ring(ring)
    );

    always #5 system_clk = ~system_clk;

    task automatic check_eq(input string tag, input int act, input int exp);
        checks_r++;
        if (act != exp) begin
            errors_r++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int to_bcd(input int v);
        return (v / 10) * 16 + (v % 10);
    endfunction

    task automatic model_step();
        int h, m, s, nt;
        bit trig, counted;
        trig = 1'b0;
        counted = 1'b0;
        m_pulse = 1'b0;
        if (CR) begin
            m_tod = 0; m_ah = ALARM_RST_HOUR; m_am = 0; m_ring = 1'b0; m_rcnt = 0;
            return;
        end
        h = m_tod / 3600; m = (m_tod / 60) % 60; s = m_tod % 60;
        if (hour_add || min_add || sec_clr) begin
            if (hour_add) h = (h + 1) % 24;
            if (min_add)  m = (m + 1) % 60;
            if (sec_clr)  s = 0;
            m_tod = h * 3600 + m * 60 + s;
        end else if (tick_1hz) begin
            counted = 1'b1;
            nt = (m_tod + 1) % 86400;
            m_pulse = (nt == 0);
            trig = (nt % 60 == 0) && alarm_en && (nt / 60 == m_ah * 60 + m_am);
            m_tod = nt;
        end
        if (!m_ring) begin
            if (trig) begin m_ring = 1'b1; m_rcnt = 0; end
        end else if (alarm_ack || !alarm_en) begin
            m_ring = 1'b0;
        end else if (counted) begin
            m_rcnt++;
            if (m_rcnt == RING_SECONDS) m_ring = 1'b0;
        end
        if (alarm_hour_add) m_ah = (m_ah + 1) % 24;
        if (alarm_min_add)  m_am = (m_am + 1) % 60;
    endtask

    task automatic check_all();
        check_eq("hour",      int'(hour),   m_tod / 3600);
        check_eq("minute",    int'(minute), (m_tod / 60) % 60);
        check_eq("second",    int'(second), m_tod % 60);
        check_eq("hour_bcd",  int'(hour_bcd), to_bcd(m_tod / 3600));
        check_eq("min_bcd",   int'(min_bcd),  to_bcd((m_tod / 60) % 60));
        check_eq("sec_bcd",   int'(sec_bcd),  to_bcd(m_tod % 60));
        check_eq("al_h_bcd",  int'(alarm_hour_bcd), to_bcd(m_ah));
        check_eq("al_m_bcd",  int'(alarm_min_bcd),  to_bcd(m_am));
        check_eq("pulse_day", int'(pulse_day), int'(m_pulse));
        check_eq("ring",      int'(ring),      int'(m_ring));
    endtask

    // One clock: inputs applied, edge, model step, compare, strobes released.
    task automatic drive(input bit t, input bit ha, input bit ma, input bit sc,
                         input bit aha, input bit ama, input bit ack, input bit cr);
        tick_1hz = t; hour_add = ha; min_add = ma; sec_clr = sc;
        alarm_hour_add = aha; alarm_min_add = ama; alarm_ack = ack; CR = cr;
        @(posedge system_clk);
        model_step();
        #1;
        check_all();
        tick_1hz = 1'b0; hour_add = 1'b0; min_add = 1'b0; sec_clr = 1'b0;
        alarm_hour_add = 1'b0; alarm_min_add = 1'b0; alarm_ack = 1'b0; CR = 1'b0;
    endtask

    task automatic do_tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic preset(input int h, input int m, input int s);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 59; i++) begin
            if (i < h || i < m) drive(1'b0, i < h, i < m, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < s; i++) do_tick();
    endtask

    initial begin
        int pulses, pulse_at;

        // Reset state
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("rst_hour", int'(hour), 0);
        check_eq("rst_alarm_hour", int'(alarm_hour_bcd), 'h07);
        check_eq("rst_ring", int'(ring), 0);

        // A full day of ticks: exactly one pulse_day, on the last tick
        pulses = 0; pulse_at = -1;
        for (int i = 0; i < 86400; i++) begin
            do_tick();
            if (pulse_day) begin
                pulses++;
                pulse_at = i;
                check_eq("day_zero_time", int'(hour) + int'(minute) + int'(second), 0);
            end
        end
        check_eq("day_pulse_count", pulses, 1);
        check_eq("day_pulse_index", pulse_at, 86399);

        // 10:59:59 -> 11:00:00 without pulse_day
        preset(10, 59, 59);
        do_tick();
        check_eq("t11_hour", int'(hour), 11);
        check_eq("t11_min", int'(minute), 0);
        check_eq("t11_pulse", int'(pulse_day), 0);

        // 23:59:59 -> pulse_day for exactly one cycle
        preset(23, 59, 59);
        do_tick();
        check_eq("t24_pulse", int'(pulse_day), 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("t24_pulse_off", int'(pulse_day), 0);

        // min_add coinciding with a tick at 05:59:30 drops the tick
        preset(5, 59, 30);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("drop_hour", int'(hour), 5);
        check_eq("drop_min", int'(minute), 0);
        check_eq("drop_sec", int'(second), 30);

        // Alarm 07:00 rings for RING_SECONDS ticks, no retrigger at 07:01
        preset(6, 59, 59);
        alarm_en = 1'b1;
        do_tick();
        check_eq("ring_rise", int'(ring), 1);
        for (int i = 0; i < RING_SECONDS - 1; i++) do_tick();
        check_eq("ring_held", int'(ring), 1);
        do_tick();
        check_eq("ring_timeout", int'(ring), 0);
        for (int i = 0; i < 60; i++) do_tick();
        check_eq("no_retrig_min", int'(minute), 2);
        check_eq("no_retrig", int'(ring), 0);

        // Acknowledge ends the ring one cycle later
        alarm_en = 1'b0;
        preset(6, 59, 59);
        alarm_en = 1'b1;
        do_tick();
        check_eq("ack_ring_on", int'(ring), 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("ack_ring_off", int'(ring), 0);

        // Deasserting alarm_en ends the ring
        alarm_en = 1'b0;
        preset(6, 59, 59);
        alarm_en = 1'b1;
        do_tick();
        check_eq("en_ring_on", int'(ring), 1);
        alarm_en = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("en_ring_off", int'(ring), 0);

        // CR while ringing at 12:34:56
        preset(12, 33, 59);
        for (int i = 0; i < 34; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, i < 5, 1'b1, 1'b0, 1'b0);
        alarm_en = 1'b1;
        for (int i = 0; i < 57; i++) do_tick();
        check_eq("cr_pre_ring", int'(ring), 1);
        check_eq("cr_pre_sec", int'(second), 56);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("cr_ring", int'(ring), 0);
        check_eq("cr_hour_bcd", int'(hour_bcd), 'h00);
        check_eq("cr_min_bcd", int'(min_bcd), 'h00);
        check_eq("cr_sec_bcd", int'(sec_bcd), 'h00);
        check_eq("cr_alarm_hour", int'(alarm_hour_bcd), 'h07);
        check_eq("cr_alarm_min", int'(alarm_min_bcd), 'h00);

        // Random strobes near an alarm boundary against the model
        preset(6, 58, 0);
        alarm_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) alarm_en = ~alarm_en;
            drive($urandom_range(0, 3) != 0,
                  $urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 29) == 0, $urandom_range(0, 59) == 0,
                  $urandom_range(0, 59) == 0, $urandom_range(0, 49) == 0,
                  $urandom_range(0, 999) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks_r, errors_r);
        $finish;
    end

endmodule
